// File: rtl/digit_frame_binarizer.sv
// digit_frame_binarizer: box-downsamples a 28*SCALE square grayscale pixel
// stream to 28x28, thresholds each box to one bit, assembles the 784-bit
// layer_0 vector, pulses nn_start and freezes layer_0 until nn_finish.
module digit_frame_binarizer #(
    parameter int SCALE     = 4,
    parameter int PIX_BITS  = 8,
    parameter int THRESH    = 128,
    parameter int MIN_COUNT = SCALE * SCALE / 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [PIX_BITS-1:0] pix_data,
    input  logic                pix_sof,
    output logic [783:0]        layer_0,
    output logic                nn_start,
    input  logic                nn_finish,
    output logic                frame_err
);

    localparam int NBOX  = 28;
    localparam int BOX_W = 5;
    localparam int CNT_W = $clog2(SCALE * SCALE + 1);
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [PIX_BITS-1:0] THRESH_V = PIX_BITS'(THRESH);
    localparam logic [CNT_W-1:0]    MIN_V    = CNT_W'(MIN_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_LAUNCH  = 2'd2,
        ST_WAIT_NN = 2'd3
    } state_t;

    state_t             state_r;
    logic               pix_ready_r;
    logic               nn_start_r;
    logic               frame_err_r;
    logic [783:0]       layer_r;
    logic [CNT_W-1:0]   cnt_r [NBOX];
    // Position of the next expected pixel, split into sub-box and box coordinates
    logic [SUB_W-1:0]   sx_r, sy_r;
    logic [BOX_W-1:0]   bx_r, by_r;

    logic               xfer_s, restart_s, accept_s, err_s, ink_s;
    logic               box_done_s, last_s, box_bit_s;
    logic [SUB_W-1:0]   cur_sx_s, cur_sy_s, nxt_sx_s, nxt_sy_s;
    logic [BOX_W-1:0]   cur_bx_s, cur_by_s, nxt_bx_s, nxt_by_s;
    logic [CNT_W-1:0]   base_cnt_s, box_sum_s;
    logic [9:0]         bit_idx_s;

    assign pix_ready = pix_ready_r;
    assign nn_start  = nn_start_r;
    assign frame_err = frame_err_r;
    assign layer_0   = layer_r;

    // Decode the current transfer: pixel coordinates, box accumulation and next position
    always_comb begin
        xfer_s    = pix_valid && pix_ready_r;
        restart_s = xfer_s && pix_sof && ((state_r == ST_IDLE) || (state_r == ST_ACC));
        accept_s  = xfer_s && ((state_r == ST_ACC) || restart_s);
        err_s     = xfer_s && pix_sof && (state_r == ST_ACC) &&
                    !((sx_r == '0) && (bx_r == '0) && (sy_r == '0) && (by_r == '0));

        // A start-of-frame pixel is always (0,0) with empty counters
        if (restart_s) begin
            cur_sx_s   = '0;
            cur_sy_s   = '0;
            cur_bx_s   = '0;
            cur_by_s   = '0;
            base_cnt_s = '0;
        end else begin
            cur_sx_s   = sx_r;
            cur_sy_s   = sy_r;
            cur_bx_s   = bx_r;
            cur_by_s   = by_r;
            base_cnt_s = cnt_r[bx_r];
        end

        if (pix_data >= THRESH_V) begin
            ink_s = 1'b1;
        end else begin
            ink_s = 1'b0;
        end

        box_sum_s  = base_cnt_s + CNT_W'(ink_s);
        box_done_s = (cur_sx_s == SUB_W'(SCALE - 1)) && (cur_sy_s == SUB_W'(SCALE - 1));
        last_s     = box_done_s && (cur_bx_s == BOX_W'(NBOX - 1)) && (cur_by_s == BOX_W'(NBOX - 1));
        box_bit_s  = (box_sum_s >= MIN_V);
        bit_idx_s  = 10'd783 - ((10'd28 * 10'(cur_by_s)) + 10'(cur_bx_s));

        nxt_sx_s = cur_sx_s;
        nxt_sy_s = cur_sy_s;
        nxt_bx_s = cur_bx_s;
        nxt_by_s = cur_by_s;
        // Raster advance: x (sub, box) wraps into y (sub, box)
        if (cur_sx_s == SUB_W'(SCALE - 1)) begin
            nxt_sx_s = '0;
            if (cur_bx_s == BOX_W'(NBOX - 1)) begin
                nxt_bx_s = '0;
                if (cur_sy_s == SUB_W'(SCALE - 1)) begin
                    nxt_sy_s = '0;
                    if (cur_by_s == BOX_W'(NBOX - 1)) begin
                        nxt_by_s = '0;
                    end else begin
                        nxt_by_s = cur_by_s + BOX_W'(1);
                    end
                end else begin
                    nxt_sy_s = cur_sy_s + SUB_W'(1);
                end
            end else begin
                nxt_bx_s = cur_bx_s + BOX_W'(1);
            end
        end else begin
            nxt_sx_s = cur_sx_s + SUB_W'(1);
        end
    end

    // Control FSM with registered handshake and pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            pix_ready_r <= 1'b0;
            nn_start_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            nn_start_r  <= 1'b0;
            frame_err_r <= err_s;
            case (state_r)
                ST_IDLE: begin
                    pix_ready_r <= 1'b1;
                    if (restart_s) begin
                        state_r <= ST_ACC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s && last_s) begin
                        state_r     <= ST_LAUNCH;
                        pix_ready_r <= 1'b0;
                        nn_start_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_ACC;
                        pix_ready_r <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_r     <= ST_WAIT_NN;
                    pix_ready_r <= 1'b0;
                end
                ST_WAIT_NN: begin
                    if (nn_finish) begin
                        state_r     <= ST_IDLE;
                        pix_ready_r <= 1'b1;
                    end else begin
                        state_r     <= ST_WAIT_NN;
                        pix_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pix_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: pixel position, per-column box counters and the binarized image
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_r    <= '0;
            sy_r    <= '0;
            bx_r    <= '0;
            by_r    <= '0;
            layer_r <= '0;
            for (int i = 0; i < NBOX; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (accept_s) begin
            if (restart_s) begin
                layer_r <= '0;
                for (int i = 0; i < NBOX; i++) begin
                    cnt_r[i] <= '0;
                end
            end
            if (box_done_s) begin
                cnt_r[cur_bx_s]    <= '0;
                layer_r[bit_idx_s] <= box_bit_s;
            end else begin
                cnt_r[cur_bx_s] <= box_sum_s;
            end
            sx_r <= nxt_sx_s;
            sy_r <= nxt_sy_s;
            bx_r <= nxt_bx_s;
            by_r <= nxt_by_s;
        end else begin
            sx_r <= sx_r;
        end
    end

endmodule

// File: doc/digit_frame_binarizer.md
# digit_frame_binarizer

Front-end stage directly upstream of the neural-network classifier. Accepts a raster-order grayscale pixel stream of one handwritten-digit cell (28·SCALE × 28·SCALE pixels) and box-downsamples it to 28×28. Each box is thresholded to one bit, assembled into the 784-bit `layer_0` vector the classifier consumes. It then pulses the classifier's `start` and holds `layer_0` stable until the classifier reports `finish`.

## Interface
- `SCALE`, 4, downsample factor per axis; image is IMG_W = IMG_H = 28·SCALE.
- `PIX_BITS`, 8, grayscale pixel width.
- `THRESH`, 128, pixel counts as ink when `pix_data >= THRESH` (unsigned).
- `MIN_COUNT`, SCALE·SCALE/2, box bit = 1 when ink-pixel count in box `>= MIN_COUNT`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  pixel offered.
- `pix_ready`  out  1  block accepts pixel; transfer when `pix_valid && pix_ready`.
- `pix_data`  in  PIX_BITS  grayscale value.
- `pix_sof`  in  1  qualifies the transferred pixel as frame pixel (0,0).
- `layer_0`  out  784  binarized image; box (r,c) at bit `783 - (28·r + c)`.
- `nn_start`  out  1  one-cycle start pulse to the classifier.
- `nn_finish`  in  1  classifier finish pulse.
- `frame_err`  out  1  one-cycle pulse on a restarted (truncated) frame.

## Operation
- States: IDLE, ACC, LAUNCH, WAIT_NN.
- IDLE: `pix_ready=1`. Transfers without `pix_sof` are dropped. A transfer with `pix_sof` is consumed as pixel (0,0), clears `layer_0` and all box counters, and moves to ACC.
- ACC: `pix_ready=1`. Pixel counters x∈[0,IMG_W), y∈[0,IMG_H) advance per transfer, x wrapping into y.
- Box counters: 28 counters, one per box column, each of width clog2(SCALE²+1), shared across a box row.
  - Each transfer adds `(pix_data>=THRESH)` to counter `x/SCALE`.
  - On the last pixel of a box (`x%SCALE==SCALE-1 && y%SCALE==SCALE-1`), the total including the current pixel is compared with `MIN_COUNT`. The result is written to bit `783-(28·(y/SCALE)+x/SCALE)`, and that counter is cleared.
- Last pixel (x=IMG_W-1, y=IMG_H-1) transferred → LAUNCH.
- `pix_sof` on any ACC transfer other than (0,0): pulse `frame_err`, clear counters and `layer_0`, treat the pixel as (0,0), stay in ACC.
- LAUNCH: `pix_ready=0`, `nn_start=1` for exactly this cycle → WAIT_NN.
- WAIT_NN: `pix_ready=0`; `layer_0` frozen (the classifier reads it combinationally during its dense pass). `nn_finish=1` → IDLE.
- `nn_finish` outside WAIT_NN is ignored.

## Timing
- Reset (`rst=0`, asynchronous): state IDLE, `pix_ready=0` while asserted. Also `layer_0=0`, `nn_start=0`, `frame_err=0`, all counters 0.
- First cycle after reset release: `pix_ready=1`.
- `pix_ready` is registered from state. A transfer in the cycle entering LAUNCH completes the frame; no further transfers are accepted.
- Box bit is visible in `layer_0` the cycle after the box's final pixel transfers.
- Last-pixel transfer at edge T → `nn_start` high during cycle T+1 only, `layer_0` complete at T+1.
- `nn_finish` sampled at edge F → IDLE and `pix_ready=1` from F+1.
- Throughput: one pixel per cycle in ACC; `pix_valid` gaps stall counters without effect.
- `frame_err` high the cycle after the offending transfer.
- Reset mid-frame or in WAIT_NN discards everything; no `nn_start` is generated for the partial frame.

## Test plan
- All pixels 0, SCALE=4, 12544 back-to-back transfers → `layer_0=0`; single `nn_start` the cycle after transfer 12544; `pix_ready=0` until `nn_finish`.
- Box (0,0) all pixels 255, rest 0 → only bit 783 set. Box (27,27) all 255 → only bit 0 set.
- Threshold boundary: box (5,9) with 7 pixels =128 and 9 pixels =127 → bit 783-149 = 0. With 8 pixels =128 → bit 634 = 1.
- Backpressure: `pix_valid` held high during WAIT_NN for 50 cycles → no transfers, `layer_0` unchanged. `nn_finish` pulse → `pix_ready=1` next cycle; a non-sof pixel is dropped, a sof pixel starts a new frame.
- `pix_sof` reasserted at pixel 3000 → `frame_err` one-cycle pulse, `layer_0` cleared. A following full 12544-pixel frame yields a correct image and one `nn_start`.
- Random `pix_valid` gaps versus gap-free run on the same image → identical `layer_0`. `rst` low at pixel 6000 → all outputs 0 immediately, no `nn_start`.
